lock_sequencer: RTL and testbench

Central controller for the door lock. Arbitrates open/close requests from the UART command decoder and the local push-button, then drives the servo position select (pos_sel into servo_control). Sequences servo travel time, auto-relock timeout and buzzer feedback patterns. Replaces the ad-hoc edge-triggered buzzer logic at the top level.

---
 rtl/lock_sequencer_pkg.sv | 31 +++
 rtl/lock_sequencer_beeper.sv | 67 ++++++
 rtl/lock_sequencer.sv | 122 ++++++++++++
 tb/tb_lock_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_sequencer_pkg.sv
// Shared definitions for the door-lock controller.
//   - lock_state_e : FSM state encodings, visible on lock_state
//   - CMD_OPEN / CMD_CLOSE : meaning of the UART command bit
//   - DEF_* : default timing constants (cycles at 50 MHz)
//   - cnt_width() : width of a counter that must hold every timing value
package lock_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_OPENING  = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_CLOSING  = 2'd3
  } lock_state_e;

  localparam logic CMD_OPEN  = 1'b1;
  localparam logic CMD_CLOSE = 1'b0;

  localparam int DEF_TRAVEL_CYC    = 25000000;   // 0.5 s servo travel
  localparam int DEF_BEEP_CYC      = 5000000;    // 0.1 s beep / gap
  localparam int DEF_AUTO_LOCK_CYC = 500000000;  // 10 s before relock

  // $clog2 of the largest timing value, never less than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lock_sequencer_beeper.sv
// Buzzer pattern generator.
//   clk, rst   : clock, asynchronous active-low reset
//   start_i    : begin a new pattern (overrides abort_i and any running one)
//   count_i    : number of beeps, 1 or 2
//   abort_i    : stop immediately, buzzer silent
//   buzzer_o   : active-low buzzer drive (registered), low for BEEP_CYC per
//                beep with a BEEP_CYC gap between beeps
module lock_sequencer_beeper #(
  parameter int BEEP_CYC = 4,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [1:0] count_i,
  input  logic       abort_i,
  output logic       buzzer_o
);

  localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYC - 1);

  // Phases alternate beep (even) / gap (odd); last_q is the final beep phase.
  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    phase_q;
  logic [1:0]    last_q;
  logic          buzzer_q;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 2'd0;
      last_q   <= 2'd0;
      buzzer_q <= 1'b1;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      phase_q  <= 2'd0;
      last_q   <= (count_i == 2'd2) ? 2'd2 : 2'd0;
      buzzer_q <= 1'b0;
    end else if (abort_i) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      buzzer_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == BEEP_LAST) begin
        cnt_q <= '0;
        if (phase_q == last_q) begin
          run_q    <= 1'b0;
          buzzer_q <= 1'b1;
        end else begin
          phase_q  <= phase_q + 2'd1;
          // Leaving an even (beep) phase enters a gap, and vice versa.
          buzzer_q <= ~phase_q[0];
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign buzzer_o = buzzer_q;

endmodule

// File: rtl/lock_sequencer.sv
// Door-lock sequencer: arbitrates UART and push-button requests, drives the
// servo position select, times servo travel and auto-relock, and triggers
// buzzer feedback (one beep opening, two beeps closing).
//   clk, rst        : 50 MHz clock, asynchronous active-low reset
//   uart_cmd_valid  : 1-cycle pulse, uart_cmd valid (1=open, 0=close)
//   btn_toggle      : 1-cycle pulse from debounced button, toggles the lock
//   pos_sel         : servo target, 0=locked, 1=open
//   buzzer          : active-low buzzer drive
//   busy            : servo travelling (OPENING/CLOSING)
//   lock_state      : current state encoding (lock_state_e)
//   req_reject      : 1-cycle pulse, a request was dropped
// All outputs are registered.
module lock_sequencer
  import lock_sequencer_pkg::*;
#(
  parameter int TRAVEL_CYC    = DEF_TRAVEL_CYC,
  parameter int BEEP_CYC      = DEF_BEEP_CYC,
  parameter int AUTO_LOCK_CYC = DEF_AUTO_LOCK_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_cmd_valid,
  input  logic       uart_cmd,
  input  logic       btn_toggle,
  output logic       pos_sel,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] lock_state,
  output logic       req_reject
);

  if (TRAVEL_CYC < 1 || BEEP_CYC < 1 || AUTO_LOCK_CYC < 1 ||
      TRAVEL_CYC < 3 * BEEP_CYC) begin : g_bad_params
    $error("lock_sequencer: need all timings >= 1 and TRAVEL_CYC >= 3*BEEP_CYC");
  end

  localparam int            CW          = cnt_width(TRAVEL_CYC, BEEP_CYC, AUTO_LOCK_CYC);
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYC - 1);
  localparam logic [CW-1:0] AUTO_LAST   = CW'(AUTO_LOCK_CYC - 1);

  lock_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;  // travel time in OPENING/CLOSING, relock timer in UNLOCKED
  logic          pos_sel_q, busy_q, req_reject_q;

  logic       want_open, want_close, reject_d, cnt_restart;
  logic       entering, start_beep, abort_beep;
  logic [1:0] beep_count;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    want_open   = 1'b0;
    want_close  = 1'b0;
    reject_d    = 1'b0;
    cnt_restart = 1'b0;
    state_d     = state_q;

    // UART beats the button; the button's meaning depends on the lock state.
    if (state_q == ST_OPENING || state_q == ST_CLOSING) begin
      reject_d = uart_cmd_valid | btn_toggle;
    end else if (uart_cmd_valid) begin
      want_open  = (uart_cmd == CMD_OPEN);
      want_close = (uart_cmd == CMD_CLOSE);
      reject_d   = btn_toggle;
    end else if (btn_toggle) begin
      want_open  = (state_q == ST_LOCKED);
      want_close = (state_q == ST_UNLOCKED);
    end

    unique case (state_q)
      ST_LOCKED:   if (want_open) state_d = ST_OPENING;
      ST_OPENING:  if (cnt_q == TRAVEL_LAST) state_d = ST_UNLOCKED;
      ST_UNLOCKED: begin
        // Expiry and close may coincide; both lead to one CLOSING entry.
        if (cnt_q == AUTO_LAST || want_close) state_d = ST_CLOSING;
        else if (want_open)                   cnt_restart = 1'b1;
      end
      ST_CLOSING:  if (cnt_q == TRAVEL_LAST) state_d = ST_LOCKED;
      default:     state_d = ST_LOCKED;
    endcase

    entering   = (state_d != state_q);
    start_beep = entering && (state_d == ST_OPENING || state_d == ST_CLOSING);
    beep_count = (state_d == ST_CLOSING) ? 2'd2 : 2'd1;
    abort_beep = entering && (state_q == ST_OPENING || state_q == ST_CLOSING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LOCKED;
      cnt_q        <= '0;
      pos_sel_q    <= 1'b0;
      busy_q       <= 1'b0;
      req_reject_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Held at zero while LOCKED, cleared on every state entry.
      cnt_q        <= (entering || cnt_restart || state_d == ST_LOCKED) ? '0 : cnt_q + 1'b1;
      pos_sel_q    <= (state_d == ST_OPENING || state_d == ST_UNLOCKED);
      busy_q       <= (state_d == ST_OPENING || state_d == ST_CLOSING);
      req_reject_q <= reject_d;
    end
  end

  lock_sequencer_beeper #(
    .BEEP_CYC (BEEP_CYC),
    .CW       (CW)
  ) u_beeper (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_beep),
    .count_i  (beep_count),
    .abort_i  (abort_beep),
    .buzzer_o (buzzer)
  );

  assign pos_sel    = pos_sel_q;
  assign busy       = busy_q;
  assign lock_state = state_q;
  assign req_reject = req_reject_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer with short timings. The reference
// model tracks the current state and the cycle it was entered; outputs are
// derived from the time spent in the state.
module tb_lock_sequencer;

  localparam int T = 20;  // travel
  localparam int B = 4;   // beep
  localparam int A = 50;  // auto-lock

  logic       clk = 1'b0;
  logic       rst;
  logic       v, c, b;
  logic       pos_sel, buzzer, busy, req_reject;
  logic [1:0] lock_state;

  lock_sequencer #(
    .TRAVEL_CYC    (T),
    .BEEP_CYC      (B),
    .AUTO_LOCK_CYC (A)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_cmd_valid (v),
    .uart_cmd       (c),
    .btn_toggle     (b),
    .pos_sel        (pos_sel),
    .buzzer         (buzzer),
    .busy           (busy),
    .lock_state     (lock_state),
    .req_reject     (req_reject)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // States as numbers: 0 locked, 1 opening, 2 unlocked, 3 closing.
  int m_state = 0;
  int m_entry = 0;  // cycle index at which the current state (or timer) began
  int m_cyc   = 0;
  bit m_rej   = 0;

  task automatic model_reset();
    m_state = 0;
    m_entry = m_cyc;
    m_rej   = 0;
  endtask

  task automatic model_edge(input bit iv, input bit ic, input bit ib);
    int  t;
    bit  op, cl;
    t  = m_cyc - m_entry;
    op = 0;
    cl = 0;
    if (m_state == 1 || m_state == 3) m_rej = iv | ib;
    else if (iv) begin op = ic; cl = !ic; m_rej = ib; end
    else begin op = ib && m_state == 0; cl = ib && m_state == 2; m_rej = 0; end
    case (m_state)
      0: if (op) begin m_state = 1; m_entry = m_cyc + 1; end
      1: if (t == T - 1) begin m_state = 2; m_entry = m_cyc + 1; end
      2: if (t == A - 1 || cl) begin m_state = 3; m_entry = m_cyc + 1; end
         else if (op) m_entry = m_cyc + 1;
      default: if (t == T - 1) begin m_state = 0; m_entry = m_cyc + 1; end
    endcase
    m_cyc++;
  endtask

  function automatic bit exp_buzzer();
    int t;
    t = m_cyc - m_entry;
    if (m_state == 1) return !(t < B);
    if (m_state == 3) return !((t < B) || (t >= 2 * B && t < 3 * B));
    return 1'b1;
  endfunction

  task automatic check_model();
    check($sformatf("state@%0d", m_cyc),  32'(lock_state), 32'(m_state));
    check($sformatf("pos_sel@%0d", m_cyc), 32'(pos_sel), 32'(m_state == 1 || m_state == 2));
    check($sformatf("busy@%0d", m_cyc),   32'(busy), 32'(m_state == 1 || m_state == 3));
    check($sformatf("buzzer@%0d", m_cyc), 32'(buzzer), 32'(exp_buzzer()));
    check($sformatf("reject@%0d", m_cyc), 32'(req_reject), 32'(m_rej));
  endtask

  // One clock: apply inputs, clock, advance model, sample #1 after the edge.
  task automatic step(input bit iv, input bit ic, input bit ib);
    v = iv; c = ic; b = ib;
    @(posedge clk);
    model_edge(iv, ic, ib);
    #1;
    v = 0; c = 0; b = 0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; v = 0; c = 0; b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(lock_state), 0);
    check("reset_pos",   32'(pos_sel), 0);
    check("reset_buzz",  32'(buzzer), 1);
    check("reset_busy",  32'(busy), 0);
    check("reset_rej",   32'(req_reject), 0);
    rst = 1'b1;
    model_reset();

    // Open by UART at cycle 10: one long beep, UNLOCKED 20 cycles later.
    idle(9);
    step(1, 1, 0);
    check("open_state", 32'(lock_state), 1);
    check("open_pos",   32'(pos_sel), 1);
    check("open_busy",  32'(busy), 1);
    check("open_buzz",  32'(buzzer), 0);
    for (int i = 1; i < T; i++) begin
      step(0, 0, 0);
      if (i == B - 1) check("open_beep_end", 32'(buzzer), 0);
      if (i == B)     check("open_beep_off", 32'(buzzer), 1);
    end
    check("open_last", 32'(lock_state), 1);
    step(0, 0, 0);
    check("unlocked", 32'(lock_state), 2);
    check("unlocked_busy", 32'(busy), 0);

    // Auto relock after A cycles, two beeps while closing.
    idle(A - 1);
    check("auto_wait", 32'(lock_state), 2);
    step(0, 0, 0);
    check("auto_close", 32'(lock_state), 3);
    check("close_pos",  32'(pos_sel), 0);
    for (int i = 1; i < T; i++) begin
      step(0, 0, 0);
      if (i == B)         check("close_gap",    32'(buzzer), 1);
      if (i == 2 * B)     check("close_beep2",  32'(buzzer), 0);
      if (i == 3 * B)     check("close_silent", 32'(buzzer), 1);
    end
    step(0, 0, 0);
    check("relocked", 32'(lock_state), 0);

    // UART open and button together: UART wins, button rejected once.
    step(1, 1, 1);
    check("both_state", 32'(lock_state), 1);
    check("both_rej",   32'(req_reject), 1);
    step(0, 0, 0);
    check("both_rej_clr", 32'(req_reject), 0);

    // Button mid-travel: rejected, travel timing unchanged.
    idle(3);
    step(0, 0, 1);
    check("busy_rej", 32'(req_reject), 1);
    idle(T - 6);
    check("busy_travel", 32'(lock_state), 1);
    step(0, 0, 0);
    check("busy_done", 32'(lock_state), 2);

    // Open in UNLOCKED at timer 40 restarts the relock timer.
    idle(40);
    step(1, 1, 0);
    check("restart_rej", 32'(req_reject), 0);
    for (int i = 1; i < A; i++) begin
      step(0, 0, 0);
      if (i == 10) check("restart_not10", 32'(lock_state), 2);
    end
    check("restart_wait", 32'(lock_state), 2);
    step(0, 0, 0);
    check("restart_close", 32'(lock_state), 3);

    // Asynchronous reset during the first closing beep.
    idle(2);
    #3;
    rst = 1'b0;
    #1;
    check("arst_state", 32'(lock_state), 0);
    check("arst_pos",   32'(pos_sel), 0);
    check("arst_buzz",  32'(buzzer), 1);
    check("arst_busy",  32'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 0, 0);
    check("close_noop", 32'(lock_state), 0);
    check("close_norej", 32'(req_reject), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
